instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Instruction sequencer feeding the control matrix. Owns the 2-bit machine `state`, latches the fetched instruction into `opcode`/`operand` registers, and holds the `LT_flag` and `branch_flag` registers the control matrix decodes. Runs one instruction per four-state pass (fetch, decode, execute, writeback), with halt and resume control and a retired-instruction counter.

## Interface
Parameters:
- `INSTR_W`, 16: instruction word width. Opcode is `[INSTR_W-1 -: 4]`; operand is the remaining low bits.
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clock`, in, 1: the single clock; all logic is rising-edge.
- `state_machine_reset_n`, in, 1: asynchronous, active-low reset.
- `run`, in, 1: level-sampled start/resume request. Honoured only while `halted`=1.
- `mem_ready`, in, 1: RAM read data valid. Sampled only in FETCH.
- `instr_in`, in, INSTR_W: instruction word from RAM.
- `alu_lt`, in, 1: ALU less-than result. Sampled in EXECUTE.
- `state`, out, 2: current state, drives control matrix `state`.
- `opcode`, out, 4: latched opcode.
- `operand`, out, INSTR_W-4: latched operand field.
- `LT_flag`, out, 1: registered compare result.
- `branch_flag`, out, 1: branch-taken indication.
- `halted`, out, 1: sequencer is stopped in FETCH.
- `retired`, out, CNT_W: count of completed instructions.

## Operation
States, in encoding order:
- FETCH, 0.
- DECODE, 1.
- EXECUTE, 2.
- WRITEBACK, 3.

Reset values: `state`=FETCH, `opcode`=4'b1111 (HALT), `operand`=0, `LT_flag`=0, `branch_flag`=0, `halted`=1, `retired`=0.

FETCH:
- While `halted`=1, stay in FETCH and ignore `mem_ready`.
- `run`=1 while `halted`=1 clears `halted` on that edge; no fetch happens on the same edge.
- While `halted`=0 and `mem_ready`=1, latch `opcode`/`operand` from `instr_in`, clear `branch_flag`, go to DECODE.
- `mem_ready`=0 stalls in FETCH with all registers held.

DECODE: always goes to EXECUTE.

EXECUTE: goes to WRITEBACK, and by opcode:
- OP_CMP (4'b0101): `LT_flag` <= `alu_lt`.
- OP_BLT (4'b0110): `branch_flag` <= `LT_flag`, using the value before this edge.
- Any other opcode leaves both flags unchanged.

WRITEBACK:
- `retired` <= `retired`+1, wrapping modulo 2^CNT_W.
- If `opcode`=OP_HALT (4'b1111), set `halted`=1.
- Always goes to FETCH.

Other rules:
- `run` is ignored while `halted`=0.
- `alu_lt` is ignored outside EXECUTE.
- `mem_ready` is ignored outside FETCH.
- `LT_flag` persists across instructions until the next CMP.
- `branch_flag` is held from the EXECUTE edge of a BLT until the next fetch latch.

## Timing
- All outputs are registered. No combinational input-to-output path.
- Minimum 4 cycles per instruction: FETCH with `mem_ready`=1, then DECODE, EXECUTE, WRITEBACK. Each `mem_ready`=0 cycle in FETCH adds one cycle.
- Resume latency: the `run` edge clears `halted`. The earliest fetch latch is the following edge.
- Reset asserted mid-instruction forces all reset values immediately, with no clock edge needed. The first clock edge after deassertion acts from FETCH with `halted`=1.
- `run` asserted together with reset: reset wins.
- HALT fetched: it still passes DECODE and EXECUTE, and is counted in `retired` at WRITEBACK. `halted` rises on the WRITEBACK edge.
- `retired` at all ones plus one retirement gives 0. There is no overflow flag.

## Structure
- Shared package `cpu_pkg` holds:
  - `state_t` enum: FETCH, DECODE, EXECUTE, WRITEBACK with the encodings above.
  - Opcode constants OP_CMP, OP_BLT, OP_HALT.
  - These are shared with the control matrix.
- No sub-module. One FSM `always_ff`, one next-state `always_comb`, one counter register.

## Test plan
- Reset, then run=1 for 1 cycle, then `mem_ready`=1 with `instr_in`=16'h1234 -> `state` goes 0,1,2,3,0; `opcode`=4'h1; `operand`=12'h234; `retired`=1.
- CMP (16'h5000) with `alu_lt`=1 in EXECUTE, then BLT (16'h6000) -> `LT_flag`=1 after CMP EXECUTE; `branch_flag`=1 from BLT EXECUTE until the next fetch latch.
- `mem_ready`=0 for 3 cycles in FETCH -> `state` stays 0 and registers hold; the instruction takes 7 cycles total.
- Fetch 16'hF000 -> `halted`=1 after WRITEBACK and `retired` increments; later `mem_ready` pulses are ignored until `run`=1.
- Assert `state_machine_reset_n`=0 mid-EXECUTE -> `state`=0, `opcode`=4'b1111, `halted`=1, `retired`=0 immediately, with no clock edge.
- Preload `retired` to 16'hFFFF by retiring instructions, then one more retirement -> `retired`=16'h0000.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// cpu_pkg: sequencer state encoding and opcode constants, shared with the control matrix.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  localparam logic [3:0] OP_CMP  = 4'b0101;
  localparam logic [3:0] OP_BLT  = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1111;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// instr_sequencer_if: RAM/ALU inputs and control-matrix outputs of the instruction sequencer.
interface instr_sequencer_if #(
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
);
  import cpu_pkg::*;

  logic               run;
  logic               mem_ready;
  logic [INSTR_W-1:0] instr_in;
  logic               alu_lt;
  state_t             state;
  logic [3:0]         opcode;
  logic [INSTR_W-5:0] operand;
  logic               LT_flag;
  logic               branch_flag;
  logic               halted;
  logic [CNT_W-1:0]   retired;

  modport master (
    output run, mem_ready, instr_in, alu_lt,
    input  state, opcode, operand, LT_flag, branch_flag, halted, retired
  );

  modport slave (
    input  run, mem_ready, instr_in, alu_lt,
    output state, opcode, operand, LT_flag, branch_flag, halted, retired
  );

endinterface : instr_sequencer_if
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// instr_sequencer: four-state fetch/decode/execute/writeback sequencer with halt/resume,
// compare and branch flags, and a retired-instruction counter. All outputs registered.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               state_machine_reset_n,
  instr_sequencer_if.slave   bus
);

  state_t             state_q, state_d;
  logic [3:0]         opcode_q;
  logic [INSTR_W-5:0] operand_q;
  logic               lt_flag_q;
  logic               branch_flag_q;
  logic               halted_q;
  logic [CNT_W-1:0]   retired_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     if (!halted_q && bus.mem_ready) state_d = DECODE;
      DECODE:    state_d = EXECUTE;
      EXECUTE:   state_d = WRITEBACK;
      WRITEBACK: state_d = FETCH;
      default:   state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge state_machine_reset_n) begin
    if (!state_machine_reset_n) begin
      state_q       <= FETCH;
      opcode_q      <= OP_HALT;
      operand_q     <= '0;
      lt_flag_q     <= 1'b0;
      branch_flag_q <= 1'b0;
      halted_q      <= 1'b1;
      retired_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FETCH: begin
          // A resume edge only clears halted; the fetch happens on the next edge.
          if (halted_q) begin
            if (bus.run) halted_q <= 1'b0;
          end else if (bus.mem_ready) begin
            opcode_q      <= bus.instr_in[INSTR_W-1 -: 4];
            operand_q     <= bus.instr_in[INSTR_W-5:0];
            branch_flag_q <= 1'b0;
          end
        end
        EXECUTE: begin
          if (opcode_q == OP_CMP) lt_flag_q     <= bus.alu_lt;
          if (opcode_q == OP_BLT) branch_flag_q <= lt_flag_q;
        end
        WRITEBACK: begin
          retired_q <= retired_q + CNT_W'(1);
          if (opcode_q == OP_HALT) halted_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state       = state_q;
  assign bus.opcode      = opcode_q;
  assign bus.operand     = operand_q;
  assign bus.LT_flag     = lt_flag_q;
  assign bus.branch_flag = branch_flag_q;
  assign bus.halted      = halted_q;
  assign bus.retired     = retired_q;

endmodule : instr_sequencer
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// tb_instr_sequencer: directed vectors with hand-computed expectations for instr_sequencer.
module tb_instr_sequencer;
  import cpu_pkg::*;

  localparam int INSTR_W = 16;
  localparam int CNT_W   = 8;  // narrow counter keeps the wrap run short

  logic clock;
  logic state_machine_reset_n;
  int   n_total;
  int   n_bad;

  instr_sequencer_if #(.INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

  instr_sequencer #(.INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clock                 (clock),
    .state_machine_reset_n (state_machine_reset_n),
    .bus                   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_instr(input logic [15:0] word);
    bus.mem_ready = 1'b1;
    bus.instr_in  = word;
    tick();
    bus.mem_ready = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int cycles;
    n_total = 0;
    n_bad   = 0;
    state_machine_reset_n = 1'b0;
    bus.run       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.instr_in  = '0;
    bus.alu_lt    = 1'b0;
    #12;
    chk("rst_state",   32'(bus.state), 0);
    chk("rst_opcode",  32'(bus.opcode), 32'hF);
    chk("rst_operand", 32'(bus.operand), 0);
    chk("rst_lt",      32'(bus.LT_flag), 0);
    chk("rst_br",      32'(bus.branch_flag), 0);
    chk("rst_halted",  32'(bus.halted), 1);
    chk("rst_retired", 32'(bus.retired), 0);
    state_machine_reset_n = 1'b1;

    // mem_ready while halted is ignored
    bus.mem_ready = 1'b1;
    bus.instr_in  = 16'h1234;
    tick();
    chk("halt_ign_state",  32'(bus.state), 0);
    chk("halt_ign_opcode", 32'(bus.opcode), 32'hF);

    // resume with mem_ready high: no fetch on the run edge
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    chk("resume_halted", 32'(bus.halted), 0);
    chk("resume_state",  32'(bus.state), 0);
    tick();
    bus.mem_ready = 1'b0;
    chk("i1_state_dec", 32'(bus.state), 1);
    chk("i1_opcode",    32'(bus.opcode), 32'h1);
    chk("i1_operand",   32'(bus.operand), 32'h234);
    tick();
    chk("i1_state_ex", 32'(bus.state), 2);
    tick();
    chk("i1_state_wb", 32'(bus.state), 3);
    tick();
    chk("i1_state_f",  32'(bus.state), 0);
    chk("i1_retired",  32'(bus.retired), 1);

    // CMP: alu_lt high only in EXECUTE
    bus.mem_ready = 1'b1;
    bus.instr_in  = 16'h5000;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    bus.alu_lt = 1'b1;
    tick();
    bus.alu_lt = 1'b0;
    chk("cmp_lt", 32'(bus.LT_flag), 1);
    tick();

    // BLT takes the branch from LT_flag
    bus.mem_ready = 1'b1;
    bus.instr_in  = 16'h6000;
    tick();
    bus.mem_ready = 1'b0;
    chk("blt_br_dec", 32'(bus.branch_flag), 0);
    tick();
    tick();
    chk("blt_br_wb", 32'(bus.branch_flag), 1);
    tick();
    chk("blt_br_f", 32'(bus.branch_flag), 1);
    chk("blt_retired", 32'(bus.retired), 3);

    // three stall cycles, then opcode 0 with alu_lt low in EXECUTE
    cycles = 0;
    repeat (3) begin
      tick();
      cycles++;
    end
    chk("stall_state",  32'(bus.state), 0);
    chk("stall_br",     32'(bus.branch_flag), 1);
    chk("stall_opcode", 32'(bus.opcode), 32'h6);
    bus.mem_ready = 1'b1;
    bus.instr_in  = 16'h0ABC;
    bus.alu_lt    = 1'b0;
    tick();
    cycles++;
    bus.mem_ready = 1'b0;
    chk("i4_br_clr",  32'(bus.branch_flag), 0);
    chk("i4_operand", 32'(bus.operand), 32'hABC);
    while (bus.state != FETCH && cycles < 20) begin
      tick();
      cycles++;
    end
    chk("stall_cycles", 32'(cycles), 7);
    chk("lt_persist",   32'(bus.LT_flag), 1);
    chk("i4_retired",   32'(bus.retired), 4);

    // HALT retires and halts at WRITEBACK
    bus.mem_ready = 1'b1;
    bus.instr_in  = 16'hF000;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    tick();
    chk("halt_pre_wb", 32'(bus.halted), 0);
    tick();
    chk("halt_halted",  32'(bus.halted), 1);
    chk("halt_retired", 32'(bus.retired), 5);
    bus.mem_ready = 1'b1;
    bus.instr_in  = 16'h1111;
    repeat (2) tick();
    chk("halt_stay_state",  32'(bus.state), 0);
    chk("halt_stay_opcode", 32'(bus.opcode), 32'hF);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    chk("rerun_state", 32'(bus.state), 0);
    tick();
    bus.mem_ready = 1'b0;
    chk("rerun_fetch", 32'(bus.opcode), 32'h1);
    tick();
    chk("pre_rst_ex", 32'(bus.state), 2);

    // async reset mid-EXECUTE, with run held high under reset
    #2;
    state_machine_reset_n = 1'b0;
    bus.run = 1'b1;
    #1;
    chk("arst_state",   32'(bus.state), 0);
    chk("arst_opcode",  32'(bus.opcode), 32'hF);
    chk("arst_halted",  32'(bus.halted), 1);
    chk("arst_retired", 32'(bus.retired), 0);
    tick();
    chk("arst_run_ign", 32'(bus.halted), 1);
    bus.run = 1'b0;
    state_machine_reset_n = 1'b1;

    // counter wrap
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    for (int i = 0; i < 255; i++) do_instr(16'h0000);
    chk("cnt_ones", 32'(bus.retired), 32'hFF);
    do_instr(16'h0000);
    chk("cnt_wrap",       32'(bus.retired), 0);
    chk("cnt_wrap_state", 32'(bus.state), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_instr_sequencer
`default_nettype wire
